charge_trigger: RTL and testbench

- Upstream sequencer for the charge tune generator.
- Merges two request sources into single-cycle `go` pulses:
  - a debounced active-low pushbutton;
  - a single-cycle `fanfare` strobe from control logic.
- Queues up to 3 pending requests.
- Holds a lockout timer sized to the full tune length, so no `go` arrives while the tune plays. The tune generator has no done output, so the lockout is the only pacing mechanism.

---
 rtl/charge_trigger.sv | 142 ++++++++++++++
 tb/tb_charge_trigger.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/charge_trigger.sv
// Request sequencer for the charge tune generator: merges a debounced pushbutton and
// a fanfare strobe into single-cycle go pulses, queued and paced by a full-tune lockout.
module charge_trigger #(
    parameter int FAST_SIM = 1,
    parameter int GAP_CLKS = 64,
    parameter int LOCK_OVR = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       fanfare,
    input  logic       clr_drop,
    output logic       go,
    output logic       busy,
    output logic [1:0] pend_cnt,
    output logic       dropped
);

    localparam logic [19:0] DEB_CLKS  = (FAST_SIM != 0) ? 20'd16 : 20'd1000000;
    localparam int          TUNE_CLKS = (FAST_SIM != 0) ? 3670016 : 58720256;
    localparam logic [25:0] LOCK_CLKS = (LOCK_OVR != 0) ? 26'(LOCK_OVR)
                                                        : 26'(TUNE_CLKS + GAP_CLKS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FIRE = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic        btn_meta_q;
    logic        btn_s_q;
    logic        deb_q, deb_d;
    logic        deb_prev_q;
    logic [19:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]  pend_q, pend_d;
    logic [25:0] timer_q, timer_d;
    logic [1:0]  state_q, state_d;
    logic        dropped_q, dropped_d;

    logic press;
    logic req;
    logic fire;
    logic drop_evt;

    // Debounced level follows btn_s only after it has disagreed for DEB_CLKS cycles
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (btn_s_q != deb_q) begin
            if (deb_cnt_q == DEB_CLKS - 20'd1) begin
                deb_d     = btn_s_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 20'd1;
            end
        end
    end

    assign press = deb_prev_q & ~deb_q;
    assign req   = press | fanfare;
    assign fire  = (state_q == FIRE);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (pend_q != 2'd0) begin
                    state_d = FIRE;
                end
            end
            FIRE: begin
                timer_d = LOCK_CLKS;
                state_d = WAIT;
            end
            WAIT: begin
                if (timer_q <= 26'd1) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 26'd1;
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // A request coinciding with the FIRE decrement leaves the count unchanged
    always_comb begin
        pend_d   = pend_q;
        drop_evt = 1'b0;
        if (req && !fire) begin
            if (pend_q == 2'd3) begin
                drop_evt = 1'b1;
            end else begin
                pend_d = pend_q + 2'd1;
            end
        end else if (!req && fire) begin
            pend_d = pend_q - 2'd1;
        end
    end

    always_comb begin
        dropped_d = dropped_q;
        if (drop_evt) begin
            dropped_d = 1'b1;
        end else if (clr_drop) begin
            dropped_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= 1'b1;
            btn_s_q    <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            deb_cnt_q  <= '0;
            pend_q     <= '0;
            timer_q    <= '0;
            state_q    <= IDLE;
            dropped_q  <= 1'b0;
        end else begin
            btn_meta_q <= btn;
            btn_s_q    <= btn_meta_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            deb_cnt_q  <= deb_cnt_d;
            pend_q     <= pend_d;
            timer_q    <= timer_d;
            state_q    <= state_d;
            dropped_q  <= dropped_d;
        end
    end

    assign go       = (state_q == FIRE);
    assign busy     = (state_q != IDLE);
    assign pend_cnt = pend_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_charge_trigger.sv
// Bench for charge_trigger: directed scenarios plus random fanfare/clr_drop traffic,
// checked against a timing-rule model of request queueing and go pacing.
module tb_charge_trigger;

    localparam int LOCK = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b1;
    logic       fanfare = 1'b0;
    logic       clr_drop = 1'b0;
    logic       go;
    logic       busy;
    logic [1:0] pend_cnt;
    logic       dropped;

    int total = 0;
    int bad = 0;

    // Model: cycle c is the interval after rising edge c
    int m_c = 0;
    int m_pend = 0;
    int m_dropped = 0;
    int m_last_go = -100000;
    bit model_on = 1'b0;
    int go_seen = 0;
    int go_q[$];

    charge_trigger #(.FAST_SIM(1), .GAP_CLKS(64), .LOCK_OVR(LOCK)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .fanfare(fanfare), .clr_drop(clr_drop),
        .go(go), .busy(busy), .pend_cnt(pend_cnt), .dropped(dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    task automatic model_reset();
        m_pend = 0;
        m_dropped = 0;
        m_last_go = -100000;
    endtask

    task automatic step();
        bit req, cd, dec, go_now, drop;
        int exp_busy, exp_go;
        req = (fanfare === 1'b1);
        cd  = (clr_drop === 1'b1);
        @(posedge clk);
        #1;
        m_c++;
        // A go may follow any cycle that is idle (lockout expired) with something queued
        dec    = (m_c - 1 == m_last_go);
        go_now = (m_c - 1 > m_last_go + LOCK) && (m_pend > 0);
        drop   = 1'b0;
        if (req && !dec) begin
            if (m_pend == 3) drop = 1'b1;
            else m_pend++;
        end else if (!req && dec) begin
            m_pend--;
        end
        if (drop) m_dropped = 1;
        else if (cd) m_dropped = 0;
        if (go_now) m_last_go = m_c;
        exp_go   = (m_c == m_last_go) ? 1 : 0;
        exp_busy = (m_c >= m_last_go && m_c <= m_last_go + LOCK) ? 1 : 0;
        if (go === 1'b1) begin
            go_seen++;
            go_q.push_back(m_c);
        end
        if (model_on) begin
            chk("go", {31'd0, go}, exp_go);
            chk("busy", {31'd0, busy}, exp_busy);
            chk("pend_cnt", {30'd0, pend_cnt}, m_pend);
            chk("dropped", {31'd0, dropped}, m_dropped);
        end
    endtask

    task automatic pulse_fanfare();
        fanfare = 1'b1;
        step();
        fanfare = 1'b0;
    endtask

    initial begin
        int k, base, busy_cnt, off;
        bit found;

        // Reset state
        step(); step();
        chk("rst_go", {31'd0, go}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_pend", {30'd0, pend_cnt}, 0);
        chk("rst_dropped", {31'd0, dropped}, 0);
        rst_n = 1'b1;
        model_reset();
        model_on = 1'b1;
        repeat (5) step();

        // 1: single fanfare
        base = go_seen;
        go_q.delete();
        pulse_fanfare();
        k = m_c;
        busy_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (busy === 1'b1) busy_cnt++;
        end
        chk("t1_go_count", go_seen - base, 1);
        chk("t1_go_cycle", go_q.size() > 0 ? go_q[0] : -1, k + 1);
        chk("t1_busy_cycles", busy_cnt, LOCK + 1);

        // 2: three requests queued during lockout
        go_q.delete();
        pulse_fanfare();
        repeat (5) step();
        for (int i = 0; i < 3; i++) begin
            pulse_fanfare();
            step();
        end
        chk("t2_pend3", {30'd0, pend_cnt}, 3);
        repeat (450) step();
        chk("t2_go_count", go_q.size(), 4);
        for (int i = 1; i < 4 && i < go_q.size(); i++)
            chk("t2_spacing", go_q[i] - go_q[i-1], LOCK + 2);
        chk("t2_dropped", {31'd0, dropped}, 0);

        // 3: overflow and clr_drop priority
        pulse_fanfare();
        repeat (3) step();
        for (int i = 0; i < 3; i++) pulse_fanfare();
        chk("t3_full", {30'd0, pend_cnt}, 3);
        pulse_fanfare();
        chk("t3_drop_set", {31'd0, dropped}, 1);
        chk("t3_pend_sat", {30'd0, pend_cnt}, 3);
        clr_drop = 1'b1; step(); clr_drop = 1'b0;
        chk("t3_drop_clr", {31'd0, dropped}, 0);
        clr_drop = 1'b1; fanfare = 1'b1; step(); clr_drop = 1'b0; fanfare = 1'b0;
        chk("t3_drop_wins", {31'd0, dropped}, 1);
        clr_drop = 1'b1; step(); clr_drop = 1'b0;
        repeat (450) step();
        chk("t3_drained", {30'd0, pend_cnt}, 0);

        // Random fanfare / clr_drop traffic
        for (int i = 0; i < 3000; i++) begin
            fanfare  = ($urandom_range(0, 39) == 0);
            clr_drop = ($urandom_range(0, 49) == 0);
            step();
        end
        fanfare = 1'b0;
        clr_drop = 1'b1; step(); clr_drop = 1'b0;
        repeat (450) step();
        chk("rand_drained", {30'd0, pend_cnt}, 0);

        // 4: debounce (model paused, directed checks)
        model_on = 1'b0;
        base = go_seen;
        btn = 1'b0;
        repeat (10) step();
        btn = 1'b1;
        repeat (60) step();
        chk("t4_glitch_no_go", go_seen - base, 0);
        chk("t4_glitch_pend", {30'd0, pend_cnt}, 0);

        go_q.delete();
        btn = 1'b0;
        k = m_c;
        repeat (40) step();
        btn = 1'b1;
        repeat (200) step();
        chk("t4_press_one_go", go_seen - base, 1);
        off = (go_q.size() > 0) ? go_q[0] - k : -1;
        chk("t4_press_latency", {31'd0, (off >= 19 && off <= 21)}, 1);

        // 5: press and fanfare coincide
        base = go_seen;
        found = 1'b0;
        btn = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (dut.press === 1'b1) begin
                pulse_fanfare();
                found = 1'b1;
                chk("t5_pend1", {30'd0, pend_cnt}, 1);
            end else begin
                step();
            end
        end
        chk("t5_press_seen", {31'd0, found}, 1);
        repeat (200) step();
        btn = 1'b1;
        repeat (80) step();
        chk("t5_one_go", go_seen - base, 1);
        chk("t5_idle", {31'd0, busy}, 0);
        model_reset();
        model_on = 1'b1;
        repeat (5) step();

        // 6: asynchronous reset mid-lockout with two pending
        pulse_fanfare();
        repeat (10) step();
        pulse_fanfare();
        pulse_fanfare();
        step();
        chk("t6_pend2", {30'd0, pend_cnt}, 2);
        chk("t6_busy", {31'd0, busy}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_go", {31'd0, go}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_pend", {30'd0, pend_cnt}, 0);
        chk("t6_rst_dropped", {31'd0, dropped}, 0);
        model_on = 1'b0;
        step(); step();
        rst_n = 1'b1;
        model_reset();
        model_on = 1'b1;
        base = go_seen;
        repeat (300) step();
        chk("t6_no_go_after", go_seen - base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
